block_cache_ctrl: RTL
=====================

Name: block_cache_ctrl

Overview:
Direct-mapped, write-back, write-allocate cache controller that sits directly upstream of delayed_memory. It serves single-word CPU loads and stores and exchanges whole blocks (BLOCK_SIZE = 2^BLOCK_OFFSET_WIDTH words) with the multi-cycle block memory. It hides memory latency on hits and handles dirty eviction and refill on misses. It also keeps hit and miss statistics for the lab's performance evaluation.

Parameters:
DATA_WIDTH, 32, word width in bits
ADDR_WIDTH, 10, CPU word-address width
BLOCK_OFFSET_WIDTH, 2, log2 words per block (BLOCK_SIZE = 4)
INDEX_WIDTH, 3, log2 number of cache lines (8 lines)
Derived: TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - BLOCK_OFFSET_WIDTH; MEM_ADDR_WIDTH = ADDR_WIDTH - BLOCK_OFFSET_WIDTH

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
cpu_req  in  1  request; held high with stable addr/we/wdata until cpu_ready
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  ADDR_WIDTH  word address {tag, index, offset}
cpu_wdata  in  DATA_WIDTH  store data
cpu_rdata  out  DATA_WIDTH  load data, valid while cpu_ready = 1
cpu_ready  out  1  one-cycle completion pulse
mem_req  out  1  memory operation request
mem_we  out  1  1 = block write-back, 0 = block fetch
mem_addr  out  MEM_ADDR_WIDTH  block address {tag, index}
mem_wdata  out  BLOCK_SIZE*DATA_WIDTH  eviction block; word 0 in the LSBs
mem_rdata  in  BLOCK_SIZE*DATA_WIDTH  fetched block, same packing
mem_valid  in  1  memory done pulse; mem_rdata is valid in the same cycle
hit_count  out  32  completed hit accesses
miss_count  out  32  miss events

Behaviour:
- Storage: per line a valid bit, a dirty bit, a TAG_WIDTH tag and a BLOCK_SIZE-word data array, all in registers.
- Reset (rst=1 at clock edge):
  - All valid and dirty bits cleared; state goes to IDLE.
  - cpu_ready, mem_req, mem_we, hit_count and miss_count are set to 0; cpu_rdata, mem_addr and mem_wdata are set to 0.
  - Data and tag arrays need not be cleared.
  - Reset overrides any state, including mid-write-back or mid-refill: mem_req drops the next cycle and the pending access is abandoned.
- FSM states: IDLE, COMPARE, WRITEBACK, ALLOCATE.
  - IDLE: when cpu_req=1, go to COMPARE. Nothing is issued to memory from IDLE.
  - COMPARE, hit (valid && tag match):
    - cpu_ready=1 for this one cycle. On a load, cpu_rdata = the addressed word.
    - On a store, the word is written at the edge and dirty is set.
    - hit_count increments only if this access did not miss earlier.
    - Next state IDLE. Hit latency is 2 cycles from the cpu_req edge.
  - COMPARE, miss:
    - miss_count increments once.
    - If valid && dirty, go to WRITEBACK; otherwise go to ALLOCATE.
    - cpu_ready stays 0.
  - WRITEBACK:
    - Drives mem_req=1, mem_we=1, mem_addr={old tag, index}, mem_wdata=line data.
    - These signals are held stable until mem_valid. On mem_valid, clear dirty and go to ALLOCATE.
  - ALLOCATE:
    - Drives mem_req=1, mem_we=0, mem_addr={new tag, index}.
    - On mem_valid, load mem_rdata into the line, set tag, valid=1, dirty=0, and go to COMPARE. The retry then hits.
    - A store miss merges cpu_wdata during the retry, not during the refill.
- mem_req deasserts in the cycle after mem_valid. Back-to-back write-back and fetch therefore have one idle cycle between them.
- cpu_req deasserted in IDLE causes no activity. Behaviour when cpu_req drops before cpu_ready is undefined; the CPU must not do it.
- A mem_valid arriving outside WRITEBACK or ALLOCATE is ignored.
- Counters wrap modulo 2^32.
- mem_wdata is a pure function of the line selected in WRITEBACK; it must not change during an outstanding write.

Test Plan:
- Cold load: after reset, load 0x005 with memory returning block 0x01 = {D3,D2,D1,D0} after 20 cycles. Required: mem_req with mem_we=0 and mem_addr=0x01; cpu_ready with cpu_rdata=D1; miss_count=1, hit_count=0.
- Load hit: load 0x006 immediately after. Required: cpu_ready 2 cycles after cpu_req with cpu_rdata=D2; no mem_req; hit_count=1.
- Dirty eviction: store 0xDEADBEEF to 0x005 (hit, dirty set), then load 0x025 (tag 1, index 1).
  - Required: write-back with mem_we=1, mem_addr=0x01 and mem_wdata word1=0xDEADBEEF.
  - Then a fetch with mem_addr=0x09 and the correct word returned; miss_count incremented by 1.
- Store miss to a clean line: store 0x12345678 to 0x044. Required: no write-back, only a fetch of 0x11; a later load of 0x044 hits and returns 0x12345678.
- Reset mid-refill: assert rst 5 cycles into ALLOCATE. Required: the next cycle has mem_req=0 and cpu_ready=0, and counters are 0. A subsequent load of 0x005 misses again (valid bits were cleared).
- Idle stability: cpu_req=0 for 50 cycles. Required: mem_req, cpu_ready and the counters all stay unchanged.

Source files
------------

// File: rtl/block_cache_ctrl.sv
// Direct-mapped write-back, write-allocate cache controller in front of a multi-cycle block memory.
// Serves single-word loads/stores, evicts dirty lines, refills on miss, and counts hits and misses.
module block_cache_ctrl #(
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned ADDR_WIDTH         = 10,
    parameter int unsigned BLOCK_OFFSET_WIDTH = 2,
    parameter int unsigned INDEX_WIDTH        = 3
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        cpu_req,
    input  logic                                        cpu_we,
    input  logic [ADDR_WIDTH-1:0]                       cpu_addr,
    input  logic [DATA_WIDTH-1:0]                       cpu_wdata,
    output logic [DATA_WIDTH-1:0]                       cpu_rdata,
    output logic                                        cpu_ready,
    output logic                                        mem_req,
    output logic                                        mem_we,
    output logic [ADDR_WIDTH-BLOCK_OFFSET_WIDTH-1:0]    mem_addr,
    output logic [(DATA_WIDTH<<BLOCK_OFFSET_WIDTH)-1:0] mem_wdata,
    input  logic [(DATA_WIDTH<<BLOCK_OFFSET_WIDTH)-1:0] mem_rdata,
    input  logic                                        mem_valid,
    output logic [31:0]                                 hit_count,
    output logic [31:0]                                 miss_count
);

    localparam int unsigned TAG_WIDTH      = ADDR_WIDTH - INDEX_WIDTH - BLOCK_OFFSET_WIDTH;
    localparam int unsigned MEM_ADDR_WIDTH = ADDR_WIDTH - BLOCK_OFFSET_WIDTH;
    localparam int unsigned BLOCK_SIZE     = 1 << BLOCK_OFFSET_WIDTH;
    localparam int unsigned NUM_LINES      = 1 << INDEX_WIDTH;
    localparam int unsigned LINE_WIDTH     = BLOCK_SIZE * DATA_WIDTH;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] COMPARE   = 2'd1;
    localparam logic [1:0] WRITEBACK = 2'd2;
    localparam logic [1:0] ALLOCATE  = 2'd3;

    typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] line_t;

    line_t                  data_q [NUM_LINES];
    logic [TAG_WIDTH-1:0]   tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0]   valid_q;
    logic [NUM_LINES-1:0]   dirty_q;

    logic [1:0]             state_q, state_d;
    logic                   missed_q, missed_d;

    logic [BLOCK_OFFSET_WIDTH-1:0] req_off;
    logic [INDEX_WIDTH-1:0]        req_idx;
    logic [TAG_WIDTH-1:0]          req_tag;
    line_t                         line_sel;
    logic                          hit;

    logic                          ready_d, mem_req_d, mem_we_d;
    logic [DATA_WIDTH-1:0]         rdata_d;
    logic [MEM_ADDR_WIDTH-1:0]     mem_addr_d;
    logic [LINE_WIDTH-1:0]         mem_wdata_d;
    logic                          hit_inc, miss_inc, line_wr, store_wr, clr_dirty;

    assign req_off  = cpu_addr[BLOCK_OFFSET_WIDTH-1:0];
    assign req_idx  = cpu_addr[BLOCK_OFFSET_WIDTH +: INDEX_WIDTH];
    assign req_tag  = cpu_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign line_sel = data_q[req_idx];
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    // Next-state and next-output logic; memory handshake only honoured while mem_req is up
    always_comb begin
        state_d     = state_q;
        missed_d    = missed_q;
        ready_d     = 1'b0;
        rdata_d     = cpu_rdata;
        mem_req_d   = 1'b0;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        hit_inc     = 1'b0;
        miss_inc    = 1'b0;
        line_wr     = 1'b0;
        store_wr    = 1'b0;
        clr_dirty   = 1'b0;
        case (state_q)
            IDLE: begin
                // cpu_ready still high means the CPU has not yet seen completion of the last access
                if (cpu_req && !cpu_ready) state_d = COMPARE;
            end
            COMPARE: begin
                if (hit) begin
                    ready_d  = 1'b1;
                    store_wr = cpu_we;
                    hit_inc  = !missed_q;
                    missed_d = 1'b0;
                    state_d  = IDLE;
                    if (!cpu_we) rdata_d = line_sel[req_off];
                end else begin
                    miss_inc  = 1'b1;
                    missed_d  = 1'b1;
                    mem_req_d = 1'b1;
                    if (valid_q[req_idx] && dirty_q[req_idx]) begin
                        state_d     = WRITEBACK;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {tag_q[req_idx], req_idx};
                        mem_wdata_d = line_sel;
                    end else begin
                        state_d    = ALLOCATE;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {req_tag, req_idx};
                    end
                end
            end
            WRITEBACK: begin
                mem_req_d = 1'b1;
                if (mem_req && mem_valid) begin
                    clr_dirty = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = ALLOCATE;
                end
            end
            default: begin
                mem_req_d  = 1'b1;
                mem_we_d   = 1'b0;
                mem_addr_d = {req_tag, req_idx};
                if (mem_req && mem_valid) begin
                    line_wr   = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = COMPARE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            missed_q   <= 1'b0;
            valid_q    <= '0;
            dirty_q    <= '0;
            cpu_ready  <= 1'b0;
            cpu_rdata  <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state_q    <= state_d;
            missed_q   <= missed_d;
            cpu_ready  <= ready_d;
            cpu_rdata  <= rdata_d;
            mem_req    <= mem_req_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            hit_count  <= hit_count + 32'(hit_inc);
            miss_count <= miss_count + 32'(miss_inc);
            if (line_wr) begin
                valid_q[req_idx] <= 1'b1;
                dirty_q[req_idx] <= 1'b0;
            end
            if (clr_dirty) dirty_q[req_idx] <= 1'b0;
            if (store_wr)  dirty_q[req_idx] <= 1'b1;
        end
    end

    // Tag and data storage carry no reset; validity alone qualifies them
    always_ff @(posedge clk) begin
        if (line_wr) begin
            data_q[req_idx] <= mem_rdata;
            tag_q[req_idx]  <= req_tag;
        end else if (store_wr) begin
            data_q[req_idx][req_off] <= cpu_wdata;
        end
    end

endmodule
